// File: rtl/seq_add_sub.sv
// rtl/seq_add_sub.sv - digit-serial adder/subtractor, DIGIT bits per cycle over WIDTH/DIGIT cycles.
module seq_add_sub #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SnA,
  output logic [WIDTH-1:0] Y,
  output logic             CO,
  output logic             OVF,
  output logic             ZERO,
  output logic             BUSY,
  output logic             DONE
);

  localparam int N  = WIDTH / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE_S} state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
  logic             co_q, co_d, ovf_q, ovf_d, zero_q, zero_d;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic [DIGIT-1:0] chunk_a, chunk_b;
  logic [DIGIT:0]   sum;
  logic             last;
  int               shamt;

  always_comb begin
    shamt   = int'(k_q) * DIGIT;
    a_sh    = a_q >> shamt;
    b_sh    = b_q >> shamt;
    chunk_a = a_sh[DIGIT-1:0];
    chunk_b = b_sh[DIGIT-1:0];
    sum     = {1'b0, chunk_a} + {1'b0, chunk_b} + {{DIGIT{1'b0}}, carry_q};
    last    = (k_q == KW'(N - 1));
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      RUN: begin
        // Unwritten Y bits are still zero, so OR-ing the chunk into place is enough.
        y_d     = y_q | (WIDTH'(sum[DIGIT-1:0]) << shamt);
        carry_d = sum[DIGIT];
        k_d     = k_q + KW'(1);
        if (last) begin
          co_d    = sum[DIGIT];
          // Same-sign operands giving an opposite-sign result == cin(msb) ^ cout(msb).
          ovf_d   = (chunk_a[DIGIT-1] == chunk_b[DIGIT-1]) &&
                    (sum[DIGIT-1] != chunk_a[DIGIT-1]);
          zero_d  = (y_d == '0);
          state_d = DONE_S;
        end
      end
      default: begin
        if (START) begin
          a_d     = A;
          b_d     = B ^ {WIDTH{SnA}};
          carry_d = SnA;
          k_d     = '0;
          y_d     = '0;
          co_d    = 1'b0;
          ovf_d   = 1'b0;
          zero_d  = 1'b0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign Y    = y_q;
  assign CO   = co_q;
  assign OVF  = ovf_q;
  assign ZERO = zero_q;
  assign BUSY = (state_q == RUN);
  assign DONE = (state_q == DONE_S);

endmodule

// File: tb/tb_seq_add_sub.sv
// tb/tb_seq_add_sub.sv - random + directed bench for seq_add_sub against an arithmetic model.
module tb_seq_add_sub;

  localparam int W = 32;
  localparam int D = 8;
  localparam int N = W / D;

  logic         CLK = 1'b0;
  logic         RST, START, SnA;
  logic [W-1:0] A, B;
  logic [W-1:0] Y;
  logic         CO, OVF, ZERO, BUSY, DONE;

  int n_tests = 0;
  int n_fail  = 0;

  seq_add_sub #(.WIDTH(W), .DIGIT(D)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .SnA(SnA),
    .Y(Y), .CO(CO), .OVF(OVF), .ZERO(ZERO), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Reference model: full result computed at capture, revealed one digit per cycle.
  int           m_left = 0;
  int           m_j    = 0;
  logic [W-1:0] m_res  = '0;
  logic [W-1:0] m_y    = '0;
  logic         m_co = 1'b0, m_ovf = 1'b0, m_zero = 1'b0, m_done = 1'b0;
  logic         m_co_f = 1'b0, m_ovf_f = 1'b0, m_zero_f = 1'b0;

  function automatic logic [W-1:0] low_mask(int j);
    logic [63:0] m;
    m = (64'd1 << (D * j)) - 64'd1;
    return m[W-1:0];
  endfunction

  always @(posedge CLK) begin
    logic [W:0]   t;
    logic [W-1:0] r;
    if (RST) begin
      m_left <= 0; m_j <= 0; m_y <= '0;
      m_co <= 1'b0; m_ovf <= 1'b0; m_zero <= 1'b0; m_done <= 1'b0;
    end else if (m_left == 0 && START) begin
      if (SnA) begin
        r = A - B;
        m_co_f  <= (A >= B);
        m_ovf_f <= (A[W-1] != B[W-1]) && (r[W-1] != A[W-1]);
      end else begin
        t = {1'b0, A} + {1'b0, B};
        r = t[W-1:0];
        m_co_f  <= t[W];
        m_ovf_f <= (A[W-1] == B[W-1]) && (r[W-1] != A[W-1]);
      end
      m_res <= r; m_zero_f <= (r == '0);
      m_left <= N; m_j <= 0; m_y <= '0;
      m_co <= 1'b0; m_ovf <= 1'b0; m_zero <= 1'b0; m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_y    <= m_res & low_mask(m_j + 1);
      m_j    <= m_j + 1;
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1; m_co <= m_co_f; m_ovf <= m_ovf_f; m_zero <= m_zero_f;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  task automatic compare_loop();
    forever begin
      @(negedge CLK);
      n_tests++;
      if (Y !== m_y || CO !== m_co || OVF !== m_ovf || ZERO !== m_zero ||
          BUSY !== (m_left > 0) || DONE !== m_done) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t got Y=%h CO=%b OVF=%b ZERO=%b BUSY=%b DONE=%b expected Y=%h CO=%b OVF=%b ZERO=%b BUSY=%b DONE=%b",
                 $time, Y, CO, OVF, ZERO, BUSY, DONE,
                 m_y, m_co, m_ovf, m_zero, (m_left > 0), m_done);
      end
    end
  endtask

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_done(output int edges);
    edges = -1;
    for (int i = 1; i <= 20; i++) begin
      if (DONE) begin
        edges = i - 1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output int busy_n, output int edges);
    A = a; B = b; SnA = s; START = 1'b1;
    @(negedge CLK);
    START = 1'b0; A = $urandom; B = $urandom; SnA = 1'($urandom);
    busy_n = 0;
    edges  = -1;
    for (int i = 1; i <= 20; i++) begin
      if (BUSY) busy_n++;
      if (DONE) begin
        edges = i - 1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h0000_00FF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int busy_n, edges, dones;
    RST = 1'b1; START = 1'b0; SnA = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge CLK);
    fork
      compare_loop();
    join_none
    check("reset_Y", Y, '0);
    check("reset_flags", {28'd0, CO, OVF, ZERO, BUSY}, '0);
    check("reset_DONE", {31'd0, DONE}, '0);
    RST = 1'b0;
    @(negedge CLK);

    do_op(32'hFFFF_FFFF, 32'h1, 1'b0, busy_n, edges);
    check("wrap_Y", Y, 32'h0);
    check("wrap_CO_ZERO_OVF", {29'd0, CO, ZERO, OVF}, {29'd0, 3'b110});
    check("wrap_busy_cycles", busy_n, 4);
    check("wrap_latency", edges, 4);
    @(negedge CLK);

    do_op(32'h7FFF_FFFF, 32'h1, 1'b0, busy_n, edges);
    check("ovf_add_Y", Y, 32'h8000_0000);
    check("ovf_add_OVF_CO", {30'd0, OVF, CO}, {30'd0, 2'b10});
    @(negedge CLK);

    do_op(32'h0000_00FF, 32'h1, 1'b0, busy_n, edges);
    check("xchunk_Y", Y, 32'h0000_0100);
    @(negedge CLK);

    do_op(32'd5, 32'd7, 1'b1, busy_n, edges);
    check("sub_neg_Y", Y, 32'hFFFF_FFFE);
    check("sub_neg_CO_OVF", {30'd0, CO, OVF}, {30'd0, 2'b00});
    @(negedge CLK);

    do_op(32'h8000_0000, 32'h1, 1'b1, busy_n, edges);
    check("sub_ovf_Y", Y, 32'h7FFF_FFFF);
    check("sub_ovf_CO_OVF", {30'd0, CO, OVF}, {30'd0, 2'b11});
    @(negedge CLK);

    // START pulsed mid-run is ignored
    A = 32'd10; B = 32'd20; SnA = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    START = 1'b1; A = 32'd999; B = 32'd1;
    @(negedge CLK);
    START = 1'b0;
    wait_done(edges);
    check("ignore_start_done", {31'd0, (edges >= 0)}, 32'd1);
    check("ignore_start_Y", Y, 32'd30);

    // Back-to-back: START held during the DONE cycle
    A = 32'd3; B = 32'd4; SnA = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check("b2b_busy", {30'd0, BUSY, DONE}, {30'd0, 2'b10});
    wait_done(edges);
    check("b2b_Y", Y, 32'd7);
    @(negedge CLK);

    // Reset during RUN cycle 2 aborts with no DONE
    A = 32'd1; B = 32'd2; SnA = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("abort_Y", Y, '0);
    check("abort_flags", {27'd0, CO, OVF, ZERO, BUSY, DONE}, '0);
    dones = 0;
    repeat (8) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    check("abort_no_done", dones, 0);

    // RST dominates START at the same edge
    RST = 1'b1; START = 1'b1; A = 32'd5; B = 32'd6;
    @(negedge CLK);
    RST = 1'b0; START = 1'b0;
    check("rst_start_busy", {31'd0, BUSY}, 32'd0);
    @(negedge CLK);

    for (int c = 0; c < 3000; c++) begin
      START = ($urandom_range(0, 3) == 0);
      RST   = ($urandom_range(0, 79) == 0);
      SnA   = 1'($urandom);
      A     = pick();
      B     = pick();
      @(negedge CLK);
    end
    RST = 1'b0; START = 1'b0;
    repeat (6) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
